// File: rtl/rca5_share_ctrl.sv
// rca5_share_ctrl: two-requester arbiter/sequencer sharing one 5-bit ripple-carry adder.
// Optional subtract mode: define RCA5_SHARE_SUB_EN. Rev 1.0
`default_nettype none

module rca5_share_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] a0,
  input  logic [4:0] b0,
  input  logic [4:0] a1,
  input  logic [4:0] b1,
  input  logic       cin0,
  input  logic       cin1,
  input  logic       op0,
  input  logic       op1,
  output logic       done0,
  output logic       done1,
  output logic [4:0] sum_o,
  output logic       cout_o,
  output logic       owner_o,
  output logic       busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] settle_cnt;
  logic [4:0] opnd_a;
  logic [4:0] opnd_b;
  logic       opnd_cin;
  logic       last_grant;
  logic       grant;

  logic [4:0] add_a;
  logic [4:0] add_b;
  logic       add_cin;
  logic [4:0] add_sum;
  logic [5:0] carry;

  // On a tie the requester that did not win last time is served.
  assign grant = (req0 && req1) ? ~last_grant : req1;

`ifdef RCA5_SHARE_SUB_EN
  logic opnd_sub;
  logic grant_op;

  assign grant_op = grant ? op1 : op0;
  assign add_b    = opnd_sub ? ~opnd_b : opnd_b;
  assign add_cin  = opnd_sub ? 1'b1 : opnd_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_sub <= 1'b0;
    end else if (state == ST_IDLE && (req0 || req1)) begin
      opnd_sub <= grant_op;
    end
  end
`else
  logic unused_op;

  assign unused_op = op0 ^ op1;
  assign add_b     = opnd_b;
  assign add_cin   = opnd_cin;
`endif

  assign add_a    = opnd_a;
  assign carry[0] = add_cin;

  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign add_sum[i]  = add_a[i] ^ add_b[i] ^ carry[i];
    assign carry[i+1]  = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= 3'd0;
      opnd_a     <= 5'd0;
      opnd_b     <= 5'd0;
      opnd_cin   <= 1'b0;
      owner_o    <= 1'b0;
      last_grant <= 1'b1;
      sum_o      <= 5'd0;
      cout_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            opnd_a     <= grant ? a1 : a0;
            opnd_b     <= grant ? b1 : b0;
            opnd_cin   <= grant ? cin1 : cin0;
            owner_o    <= grant;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (settle_cnt != 3'd0) begin
            settle_cnt <= settle_cnt - 3'd1;
          end else begin
            sum_o      <= add_sum;
            cout_o     <= carry[5];
            last_grant <= owner_o;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done0  = (state == ST_DONE) && !owner_o;
  assign done1  = (state == ST_DONE) && owner_o;

endmodule

`default_nettype wire

// File: tb/tb_rca5_share_ctrl.sv
// tb_rca5_share_ctrl: directed self-checking bench for rca5_share_ctrl (SETTLE = 2).
`default_nettype none

module tb_rca5_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [4:0] a0, b0, a1, b1;
  logic       cin0, cin1, op0, op1;
  logic       done0, done1;
  logic [4:0] sum_o;
  logic       cout_o, owner_o, busy_o;

  int checks = 0;
  int errors = 0;

  rca5_share_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1), .op0(op0), .op1(op1),
    .done0(done0), .done1(done1),
    .sum_o(sum_o), .cout_o(cout_o), .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [4:0] exp_sum [4];
  logic       exp_cout[4];

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 5'd0; b0 = 5'd0; a1 = 5'd0; b1 = 5'd0;
    cin0 = 1'b0; cin1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_sum", 32'(sum_o), 0);
    check("reset_cout", 32'(cout_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_owner", 32'(owner_o), 0);
    check("reset_done", 32'({done1, done0}), 0);

    // Reset in the middle of a transaction drops it.
    req0 = 1'b1; a0 = 5'd13; b0 = 5'd9; cin0 = 1'b1;
    tick();
    check("midrst_busy_before", 32'(busy_o), 1);
    req0 = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_sum", 32'(sum_o), 0);
    check("midrst_done", 32'({done1, done0}), 0);
    tick();
    check("midrst_done_later", 32'({done1, done0}), 0);
    check("midrst_idle_later", 32'(busy_o), 0);

    // Single add: 13 + 9 + 1 = 23.
    req0 = 1'b1; a0 = 5'd13; b0 = 5'd9; cin0 = 1'b1;
    tick();
    check("add_busy", 32'(busy_o), 1);
    check("add_done_e0", 32'(done0), 0);
    tick();
    check("add_done_e1", 32'(done0), 0);
    tick();
    check("add_done0", 32'(done0), 1);
    check("add_done1", 32'(done1), 0);
    check("add_sum", 32'(sum_o), 23);
    check("add_cout", 32'(cout_o), 0);
    check("add_owner", 32'(owner_o), 0);
    req0 = 1'b0;
    tick();
    check("add_done_clear", 32'(done0), 0);
    check("add_idle", 32'(busy_o), 0);

    // Wrap: 31 + 0 + 1 = 32 -> 0 carry 1.
    req1 = 1'b1; a1 = 5'd31; b1 = 5'd0; cin1 = 1'b1;
    tick(); tick(); tick();
    check("wrap_done1", 32'(done1), 1);
    check("wrap_done0", 32'(done0), 0);
    check("wrap_sum", 32'(sum_o), 0);
    check("wrap_cout", 32'(cout_o), 1);
    check("wrap_owner", 32'(owner_o), 1);
    req1 = 1'b0;
    tick();

    // Tie: both held high, grants alternate 0,1,0,1 every 4 cycles.
    a0 = 5'd1;  b0 = 5'd2;  cin0 = 1'b0;
    a1 = 5'd20; b1 = 5'd15; cin1 = 1'b1;
    exp_sum[0] = 5'd3; exp_cout[0] = 1'b0;
    exp_sum[1] = 5'd4; exp_cout[1] = 1'b1;
    exp_sum[2] = 5'd3; exp_cout[2] = 1'b0;
    exp_sum[3] = 5'd4; exp_cout[3] = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); tick(); tick();
      check("tie_owner", 32'(owner_o), 32'(i % 2));
      check("tie_done", 32'({done1, done0}), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("tie_sum", 32'(sum_o), 32'(exp_sum[i]));
      check("tie_cout", 32'(cout_o), 32'(exp_cout[i]));
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
    end
    check("tie_idle", 32'(busy_o), 0);

    // Operand change and req drop during RUN are ignored.
    req0 = 1'b1; a0 = 5'd7; b0 = 5'd8; cin0 = 1'b0;
    tick();
    a0 = 5'd20; req0 = 1'b0;
    tick(); tick();
    check("mid_done0", 32'(done0), 1);
    check("mid_sum", 32'(sum_o), 15);
    check("mid_owner", 32'(owner_o), 0);
    tick();
    check("mid_idle", 32'(busy_o), 0);
    tick();
    check("mid_no_new", 32'(busy_o), 0);

    // Subtract request: 5 op 3 and 3 op 5.
    req0 = 1'b1; op0 = 1'b1; a0 = 5'd5; b0 = 5'd3; cin0 = 1'b0;
    tick(); tick(); tick();
    check("sub1_done0", 32'(done0), 1);
`ifdef RCA5_SHARE_SUB_EN
    check("sub1_sum", 32'(sum_o), 2);
    check("sub1_cout", 32'(cout_o), 1);
`else
    check("sub1_sum", 32'(sum_o), 8);
    check("sub1_cout", 32'(cout_o), 0);
`endif
    req0 = 1'b0;
    tick();
    req0 = 1'b1; a0 = 5'd3; b0 = 5'd5;
    tick(); tick(); tick();
    check("sub2_done0", 32'(done0), 1);
`ifdef RCA5_SHARE_SUB_EN
    check("sub2_sum", 32'(sum_o), 30);
    check("sub2_cout", 32'(cout_o), 0);
`else
    check("sub2_sum", 32'(sum_o), 8);
    check("sub2_cout", 32'(cout_o), 0);
`endif
    req0 = 1'b0; op0 = 1'b0;
    tick();
    check("final_idle", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
